// File: rtl/phv_out_buffer_pkg.sv
// Shared PHV pipeline definitions used by the last stage, this buffer and the deparser.
package phv_out_buffer_pkg;

  // 48 x 8b + 32 x 8b + 16 x 8b containers plus 256 bits of metadata.
  localparam int PHV_LEN_DEFAULT = 48 * 8 + 32 * 8 + 16 * 8 + 256;

  // Bits needed to hold an entry count in the range 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/phv_fifo_mem.sv
// PHV storage: synchronous write, asynchronous read, so the head entry falls through.
module phv_fifo_mem #(
  parameter int PHV_LEN = 1024,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [PHV_LEN-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [PHV_LEN-1:0] rdata
);

  logic [PHV_LEN-1:0] mem_q [DEPTH];

  // Write port; contents are never reset, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/phv_out_buffer.sv
// Elastic PHV buffer between the last pipeline stage and the deparser.
// The upstream never stalls on this block; the advisory ready drops early enough
// that the SKID in-flight PHVs still fit, and anything beyond that is counted.
module phv_out_buffer
  import phv_out_buffer_pkg::*;
#(
  parameter int PHV_LEN = PHV_LEN_DEFAULT,
  parameter int DEPTH   = 16,
  parameter int SKID    = 6,
  parameter int CNT_W   = 32
) (
  input  logic                           axis_clk,
  input  logic                           areset,
  input  logic [PHV_LEN-1:0]             phv_in,
  input  logic                           phv_in_valid,
  output logic                           phv_fifo_ready,
  output logic [PHV_LEN-1:0]             phv_out,
  output logic                           phv_out_valid,
  input  logic                           phv_out_ready,
  output logic [occ_width(DEPTH)-1:0]    occupancy,
  output logic [CNT_W-1:0]               drop_cnt,
  output logic                           overflow
);

  localparam int OCC_W = occ_width(DEPTH);
  localparam int AW    = $clog2(DEPTH);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_THR  = OCC_W'(DEPTH - SKID);

  // Drop counter holds at all-ones instead of wrapping back to a small value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  logic             pop;
  logic             push;
  logic             drop;
  logic             full;

  // Next-state for pointers, occupancy, ready and drop accounting.
  always_comb begin
    pop  = (occ_q != '0) && phv_out_ready;
    full = (occ_q == OCC_FULL);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    push = phv_in_valid && (!full || pop);
    drop = phv_in_valid && full && !pop;

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    // Ready is computed from the post-edge count so it tracks occupancy with no lag.
    ready_d    = (occ_d < OCC_THR);
    drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    overflow_d = overflow_q | drop;
  end

  // Control state; reset discards all buffered PHVs by clearing the pointers.
  always_ff @(posedge axis_clk) begin
    if (areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      ready_q    <= 1'b0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      ready_q    <= ready_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  phv_fifo_mem #(
    .PHV_LEN (PHV_LEN),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_mem (
    .clk   (axis_clk),
    .we    (push && !areset),
    .waddr (wr_ptr_q),
    .wdata (phv_in),
    .raddr (rd_ptr_q),
    .rdata (phv_out)
  );

  assign phv_out_valid  = (occ_q != '0);
  assign phv_fifo_ready = ready_q;
  assign occupancy      = occ_q;
  assign drop_cnt       = drop_cnt_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_phv_out_buffer.sv
// Self-checking bench for phv_out_buffer: constant vector table, hand sequences
// for overflow / full push-pop / mid-run reset, and randomized traffic against a queue model.
module tb_phv_out_buffer;
  import phv_out_buffer_pkg::*;

  localparam int PHV_LEN = 1024;
  localparam int DEPTH   = 16;
  localparam int SKID    = 6;
  localparam int CNT_W   = 32;
  localparam int OCC_W   = occ_width(DEPTH);
  localparam int TAG_A5  = -2;
  localparam int NO_DATA = -1;

  logic                 axis_clk = 1'b0;
  logic                 areset = 1'b1;
  logic [PHV_LEN-1:0]   phv_in = '0;
  logic                 phv_in_valid = 1'b0;
  logic                 phv_fifo_ready;
  logic [PHV_LEN-1:0]   phv_out;
  logic                 phv_out_valid;
  logic                 phv_out_ready = 1'b0;
  logic [OCC_W-1:0]     occupancy;
  logic [CNT_W-1:0]     drop_cnt;
  logic                 overflow;

  phv_out_buffer #(
    .PHV_LEN (PHV_LEN),
    .DEPTH   (DEPTH),
    .SKID    (SKID),
    .CNT_W   (CNT_W)
  ) dut (
    .axis_clk       (axis_clk),
    .areset         (areset),
    .phv_in         (phv_in),
    .phv_in_valid   (phv_in_valid),
    .phv_fifo_ready (phv_fifo_ready),
    .phv_out        (phv_out),
    .phv_out_valid  (phv_out_valid),
    .phv_out_ready  (phv_out_ready),
    .occupancy      (occupancy),
    .drop_cnt       (drop_cnt),
    .overflow       (overflow)
  );

  always #5 axis_clk = ~axis_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an ordered queue of accepted PHVs plus drop bookkeeping.
  logic [PHV_LEN-1:0] mq [$];
  int m_drop = 0;
  bit m_ovf  = 1'b0;
  bit m_rdy  = 1'b0;

  function automatic logic [PHV_LEN-1:0] mk(input int tag);
    logic [PHV_LEN-1:0] p;
    if (tag == TAG_A5) begin
      p = {(PHV_LEN/8){8'hA5}};
    end else begin
      for (int i = 0; i < PHV_LEN / 32; i++) begin
        p[i*32 +: 32] = 32'(tag) * 32'h9E3779B1 + 32'(i);
      end
    end
    return p;
  endfunction

  task automatic model_step(input bit v, input logic [PHV_LEN-1:0] d, input bit r);
    bit pop;
    bit full;
    pop  = (mq.size() != 0) && r;
    full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (v) begin
      if (full && !pop) begin
        if (m_drop != 32'hFFFF_FFFF) m_drop++;
        m_ovf = 1'b1;
      end else begin
        mq.push_back(d);
      end
    end
    m_rdy = (mq.size() < DEPTH - SKID);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [PHV_LEN-1:0] act,
                          input logic [PHV_LEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got low64 %h, expected low64 %h", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".occ"},   longint'(occupancy),      longint'(mq.size()));
    chk({tag, ".valid"}, longint'(phv_out_valid),  longint'(mq.size() != 0));
    chk({tag, ".ready"}, longint'(phv_fifo_ready), longint'(m_rdy));
    chk({tag, ".drop"},  longint'(drop_cnt),       longint'(m_drop));
    chk({tag, ".ovf"},   longint'(overflow),       longint'(m_ovf));
    if (mq.size() != 0) chk_data({tag, ".data"}, phv_out, mq[0]);
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle before sampling.
  task automatic cycle(input bit v, input logic [PHV_LEN-1:0] d, input bit r);
    phv_in_valid  = v;
    phv_in        = d;
    phv_out_ready = r;
    @(posedge axis_clk);
    model_step(v, d, r);
    #1;
  endtask

  task automatic do_reset(input bit v_during);
    areset        = 1'b1;
    phv_in_valid  = v_during;
    phv_in        = mk(999);
    phv_out_ready = 1'b1;
    @(posedge axis_clk);
    mq.delete();
    m_drop = 0;
    m_ovf  = 1'b0;
    m_rdy  = 1'b0;
    #1;
    chk("rst.occ",   longint'(occupancy),      0);
    chk("rst.valid", longint'(phv_out_valid),  0);
    chk("rst.drop",  longint'(drop_cnt),       0);
    chk("rst.ovf",   longint'(overflow),       0);
    chk("rst.ready", longint'(phv_fifo_ready), 0);
    areset       = 1'b0;
    phv_in_valid = 1'b0;
  endtask

  typedef struct {
    bit vld;
    bit rdy;
    int tag;
    int e_occ;
    bit e_ovld;
    bit e_frdy;
    int e_drop;
    int e_tag;
  } vec_t;

  vec_t tbl [$];

  initial begin
    int sent;
    int recv;
    int low_cnt;
    int cyc;
    bit v;
    bit r;

    // Test 1: reset then one PHV; test 2: ten pushes with the consumer stalled.
    tbl.push_back('{1'b0, 1'b1, 0,      0, 1'b0, 1'b1, 0, NO_DATA});
    tbl.push_back('{1'b1, 1'b1, TAG_A5, 1, 1'b1, 1'b1, 0, TAG_A5});
    tbl.push_back('{1'b0, 1'b1, 0,      0, 1'b0, 1'b1, 0, NO_DATA});
    tbl.push_back('{1'b0, 1'b1, 0,      0, 1'b0, 1'b1, 0, NO_DATA});
    for (int k = 1; k <= 10; k++) begin
      tbl.push_back('{1'b1, 1'b0, k - 1, k, 1'b1, (k < DEPTH - SKID), 0, 0});
    end
    tbl.push_back('{1'b0, 1'b0, 0, 10, 1'b1, 1'b0, 0, 0});

    do_reset(1'b0);

    foreach (tbl[i]) begin
      cycle(tbl[i].vld, mk(tbl[i].tag), tbl[i].rdy);
      chk($sformatf("tbl%0d.occ", i),   longint'(occupancy),      tbl[i].e_occ);
      chk($sformatf("tbl%0d.valid", i), longint'(phv_out_valid),  tbl[i].e_ovld);
      chk($sformatf("tbl%0d.ready", i), longint'(phv_fifo_ready), tbl[i].e_frdy);
      chk($sformatf("tbl%0d.drop", i),  longint'(drop_cnt),       tbl[i].e_drop);
      if (tbl[i].e_tag != NO_DATA) chk_data($sformatf("tbl%0d.data", i), phv_out, mk(tbl[i].e_tag));
    end

    // Test 3: eight more pushes ignoring ready; the last two overflow.
    for (int k = 10; k < 18; k++) begin
      cycle(1'b1, mk(k), 1'b0);
      check_model($sformatf("ovf%0d", k));
    end
    chk("ovf.occ",  longint'(occupancy), 16);
    chk("ovf.drop", longint'(drop_cnt),  2);
    chk("ovf.flag", longint'(overflow),  1);
    chk_data("ovf.head", phv_out, mk(0));

    // Test 4: push and pop together while full.
    cycle(1'b1, mk(100), 1'b1);
    chk("full_pp.occ",  longint'(occupancy), 16);
    chk("full_pp.drop", longint'(drop_cnt),  2);
    check_model("full_pp");
    for (int i = 0; i < 16; i++) begin
      chk_data($sformatf("drain%0d.head", i), phv_out, mk(i < 15 ? i + 1 : 100));
      cycle(1'b0, '0, 1'b1);
      check_model($sformatf("drain%0d", i));
    end
    chk("drain.occ", longint'(occupancy), 0);

    // Test 6: reset with seven entries buffered and a PHV presented in the reset cycle.
    for (int k = 0; k < 7; k++) cycle(1'b1, mk(200 + k), 1'b0);
    chk("pre_rst.occ", longint'(occupancy), 7);
    do_reset(1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("post_rst.ready", longint'(phv_fifo_ready), 1);
    chk("post_rst.occ",   longint'(occupancy),      0);
    check_model("post_rst");

    // Test 5: random traffic, upstream honours ready with up to SKID PHVs in flight.
    sent    = 0;
    recv    = 0;
    low_cnt = 0;
    cyc     = 0;
    while (recv < 100 && cyc < 3000) begin
      v = 1'b0;
      if (phv_fifo_ready) low_cnt = 0;
      if (sent < 100 && (phv_fifo_ready || low_cnt < SKID) && $urandom_range(0, 3) != 0) v = 1'b1;
      if (v && !phv_fifo_ready) low_cnt++;
      r = 1'($urandom_range(0, 1));
      if (phv_out_valid && r) begin
        chk_data($sformatf("rand.order%0d", recv), phv_out, mk(300 + recv));
        recv++;
      end
      cycle(v, mk(300 + sent), r);
      if (v) sent++;
      check_model("rand");
      if (drop_cnt != '0) chk("rand.nodrop", longint'(drop_cnt), 0);
      cyc++;
    end
    chk("rand.delivered", recv, 100);
    chk("rand.drop_end",  longint'(drop_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
